// File: rtl/cpu_pkg.sv
// Shared types and constants for the memory-bus arbitration path.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/bus_arbiter_rr.sv
// Two-port winner select: round-robin on last-served port, or fixed data-port priority.
module rr_arbiter2
    import cpu_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win
);

    // ptr is the port served last; on conflict the other one wins
    always_comb begin
        win = 2'b00;
        unique case (req)
            2'b11:   win = (RR_EN && ptr == PORT_DATA) ? 2'b01 : 2'b10;
            2'b10:   win = 2'b10;
            2'b01:   win = 2'b01;
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates fetch and data ports onto one start/complete memory bus,
// latching the winning request and aborting transactions the bus never answers.
module bus_arbiter
    import cpu_pkg::*;
#(
    parameter bit RR_EN   = 1'b1,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic        mode0,
    input  logic        mode1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] BUS_addr,
    output logic [31:0] BUS_wdata,
    output logic        BUS_mode,
    output logic        BUS_start_transaction,
    input  logic [31:0] BUS_rdata,
    input  logic        BUS_rdata_valid,
    input  logic        BUS_write_done
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic [1:0]       win;
    logic             cmpl;

    rr_arbiter2 #(
        .RR_EN(RR_EN)
    ) u_arb (
        .req(req),
        .ptr(last),
        .win(win)
    );

    // Only the completion matching the latched mode ends the transaction
    assign cmpl = (BUS_mode == MODE_WRITE) ? BUS_write_done : BUS_rdata_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            gnt                   <= 2'b00;
            done                  <= 2'b00;
            err                   <= 1'b0;
            rdata                 <= '0;
            BUS_addr              <= '0;
            BUS_wdata             <= '0;
            BUS_mode              <= MODE_READ;
            BUS_start_transaction <= 1'b0;
            cnt                   <= '0;
            last                  <= PORT_FETCH;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        gnt                   <= win;
                        BUS_addr              <= win[1] ? addr1 : addr0;
                        BUS_wdata             <= win[1] ? wdata1 : wdata0;
                        BUS_mode              <= win[1] ? mode1 : mode0;
                        BUS_start_transaction <= 1'b1;
                        state                 <= START;
                    end
                end
                START: begin
                    BUS_start_transaction <= 1'b0;
                    cnt                   <= '0;
                    state                 <= WAIT;
                end
                WAIT: begin
                    if (cmpl) begin
                        if (BUS_mode == MODE_READ) rdata <= BUS_rdata;
                        done  <= gnt;
                        err   <= 1'b0;
                        state <= DONE;
                    end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
                        rdata <= '0;
                        done  <= gnt;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 2'b00;
                    err   <= 1'b0;
                    gnt   <= 2'b00;
                    last  <= gnt[1];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench: round-robin instance a and fixed-priority instance b share all inputs.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic        mode0, mode1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [31:0] bus_rdata;
    logic        rv, wd;

    logic [1:0]  gnt, done, gnt_b, done_b;
    logic        err, err_b;
    logic [31:0] rdata, rdata_b;
    logic [31:0] baddr, baddr_b, bwdata, bwdata_b;
    logic        bmode, bmode_b, start, start_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.RR_EN(1'b1), .TIMEOUT(5), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req),
        .mode0(mode0), .mode1(mode1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .BUS_addr(baddr), .BUS_wdata(bwdata), .BUS_mode(bmode),
        .BUS_start_transaction(start),
        .BUS_rdata(bus_rdata), .BUS_rdata_valid(rv), .BUS_write_done(wd)
    );

    bus_arbiter #(.RR_EN(1'b0), .TIMEOUT(5), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .req(req),
        .mode0(mode0), .mode1(mode1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt_b), .done(done_b), .err(err_b), .rdata(rdata_b),
        .BUS_addr(baddr_b), .BUS_wdata(bwdata_b), .BUS_mode(bmode_b),
        .BUS_start_transaction(start_b),
        .BUS_rdata(bus_rdata), .BUS_rdata_valid(rv), .BUS_write_done(wd)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; mode0 = 1'b0; mode1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        bus_rdata = '0; rv = 1'b0; wd = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_start", 32'(start), 0);
        check("rst_addr", baddr, 0);
        check("rst_rdata", rdata, 0);
        check("rst_gnt_b", 32'(gnt_b), 0);
        tick();
        check("idle_gnt", 32'(gnt), 0);

        // single read, reply one cycle after start
        req = 2'b01; addr0 = 32'h10; mode0 = 1'b0;
        tick();
        check("rd_start", 32'(start), 1);
        check("rd_gnt", 32'(gnt), 1);
        check("rd_addr", baddr, 32'h10);
        check("rd_mode", 32'(bmode), 0);
        addr0 = 32'hFFFF;
        tick();
        check("rd_start_low", 32'(start), 0);
        check("rd_addr_hold", baddr, 32'h10);
        bus_rdata = 32'hDEAD_BEEF; rv = 1'b1;
        tick();
        rv = 1'b0;
        check("rd_done", 32'(done), 1);
        check("rd_rdata", rdata, 32'hDEAD_BEEF);
        check("rd_err", 32'(err), 0);
        req = 2'b00;
        tick();
        check("rd_done_clr", 32'(done), 0);
        check("rd_gnt_clr", 32'(gnt), 0);

        // single write, write_done in third WAIT cycle
        req = 2'b10; mode1 = 1'b1; addr1 = 32'h100; wdata1 = 32'h1234_5678;
        tick();
        check("wr_start", 32'(start), 1);
        check("wr_gnt", 32'(gnt), 2);
        check("wr_mode", 32'(bmode), 1);
        check("wr_wdata", bwdata, 32'h1234_5678);
        wdata1 = 32'h0;
        tick();
        check("wr_wait1", 32'(done), 0);
        tick();
        check("wr_wait2", 32'(done), 0);
        check("wr_wdata_hold", bwdata, 32'h1234_5678);
        tick();
        wd = 1'b1;
        tick();
        wd = 1'b0;
        check("wr_done", 32'(done), 2);
        check("wr_rdata_keep", rdata, 32'hDEAD_BEEF);
        check("wr_addr_hold", baddr, 32'h100);
        req = 2'b00; mode1 = 1'b0;
        tick();

        // timeout: five silent WAIT cycles
        req = 2'b01; addr0 = 32'h20;
        repeat (6) tick();
        check("to_early", 32'(done), 0);
        tick();
        check("to_done", 32'(done), 1);
        check("to_err", 32'(err), 1);
        check("to_rdata", rdata, 0);
        req = 2'b00;
        tick();
        check("to_err_clr", 32'(err), 0);

        // completion on the last allowed WAIT cycle succeeds
        req = 2'b01;
        repeat (6) tick();
        bus_rdata = 32'hA5A5_A5A5; rv = 1'b1;
        tick();
        rv = 1'b0;
        check("edge_done", 32'(done), 1);
        check("edge_err", 32'(err), 0);
        check("edge_rdata", rdata, 32'hA5A5_A5A5);
        req = 2'b00;
        tick();

        // valid during START and wrong-type completion are ignored
        req = 2'b01; addr0 = 32'h40;
        tick();
        bus_rdata = 32'h1111_1111; rv = 1'b1;
        tick();
        rv = 1'b0; wd = 1'b1; req = 2'b00;
        check("wc_start_ign", 32'(done), 0);
        tick();
        wd = 1'b0;
        check("wc_wd_ign", 32'(done), 0);
        bus_rdata = 32'hCAFE_F00D; rv = 1'b1;
        tick();
        rv = 1'b0;
        check("wc_done", 32'(done), 1);
        check("wc_rdata", rdata, 32'hCAFE_F00D);
        check("wc_err", 32'(err), 0);
        tick();

        // reset while in WAIT abandons the transaction
        req = 2'b01; addr0 = 32'h50;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 2'b00;
        check("mr_gnt", 32'(gnt), 0);
        check("mr_done", 32'(done), 0);
        check("mr_start", 32'(start), 0);
        check("mr_addr", baddr, 0);
        check("mr_rdata", rdata, 0);
        tick();
        check("mr_no_done", 32'(done), 0);
        req = 2'b01; addr0 = 32'h60;
        tick();
        check("mr_restart", 32'(start), 1);
        check("mr_addr2", baddr, 32'h60);
        tick();
        bus_rdata = 32'h77; rv = 1'b1;
        tick();
        rv = 1'b0;
        check("mr_done2", 32'(done), 1);
        check("mr_rdata2", rdata, 32'h77);
        req = 2'b00;
        tick();

        // conflict: a alternates 10,01,..; b always grants port 1
        req = 2'b11; mode0 = 1'b0; mode1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_gnt", 32'(gnt), (i % 2 == 0) ? 32'd2 : 32'd1);
            check("fp_gnt", 32'(gnt_b), 2);
            tick();
            bus_rdata = 32'(i); rv = 1'b1;
            tick();
            rv = 1'b0;
            check("rr_done", 32'(done), (i % 2 == 0) ? 32'd2 : 32'd1);
            check("fp_done", 32'(done_b), 2);
            tick();
        end
        req = 2'b00;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
